// File: rtl/joy_serial_scanner.sv
// joy_serial_scanner: scans a daisy-chained 74HC165-style joystick chain of
// NUM_JOY ports x BITS_PER_JOY bits and presents a frame-atomic, active-low
// button vector to the machine core.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       scanning allowed (only looked at while idle)
//   swap         exchange port 0 / port 1 fields at commit (NUM_JOY > 1)
//   joy_data     serial data from the chain, active-low buttons
//   joy_clk      chain shift clock
//   joy_load_n   chain parallel-load strobe, active-low
//   joy_state    latched button vector; port p at [(NUM_JOY-p)*BITS_PER_JOY-1 -: BITS_PER_JOY]
//   frame_done   one-clk pulse when joy_state updates
//   frame_count  completed frames, wraps at 256
module joy_serial_scanner #(
  parameter int unsigned CLKDIV       = 12,
  parameter int unsigned NUM_JOY      = 2,
  parameter int unsigned BITS_PER_JOY = 12,
  parameter int unsigned SCAN_GAP     = 1000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            swap,
  input  logic                            joy_data,
  output logic                            joy_clk,
  output logic                            joy_load_n,
  output logic [NUM_JOY*BITS_PER_JOY-1:0] joy_state,
  output logic                            frame_done,
  output logic [7:0]                      frame_count
);

  localparam int unsigned TOTAL = NUM_JOY * BITS_PER_JOY;
  localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam int unsigned BIT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(SCAN_GAP - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [GAP_W-1:0]   gap_q;
  logic [BIT_W-1:0]   bit_q;
  logic               load_cnt_q;
  logic               phase_q;
  logic [TOTAL-1:0]   shreg_q;
  logic [TOTAL-1:0]   shreg_d;
  logic [TOTAL-1:0]   commit_d;
  logic               tick;

  assign tick = (div_q == DIV_MAX);

  // Shift left, new bit into the LSB; the first bit received ends in the MSB.
  assign shreg_d = TOTAL'({shreg_q, joy_data});

  // Port 0/1 exchange applied on the way into joy_state.
  if (NUM_JOY > 1) begin : g_swap
    always_comb begin
      commit_d = shreg_q;
      if (swap) begin
        commit_d[TOTAL-1 -: BITS_PER_JOY]              = shreg_q[TOTAL-BITS_PER_JOY-1 -: BITS_PER_JOY];
        commit_d[TOTAL-BITS_PER_JOY-1 -: BITS_PER_JOY] = shreg_q[TOTAL-1 -: BITS_PER_JOY];
      end
    end
  end else begin : g_noswap
    assign commit_d = shreg_q;
  end

  // Scan sequencer: IDLE gap -> LOAD (2 ticks) -> SHIFT (2 ticks/bit) -> COMMIT (1 clk).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
      load_cnt_q  <= 1'b0;
      phase_q     <= 1'b0;
      shreg_q     <= '1;
      joy_clk     <= 1'b0;
      joy_load_n  <= 1'b1;
      joy_state   <= '1;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_done <= 1'b0;

      // The commit clk does not advance the divider, so it adds one clk to
      // every frame period on top of the tick-aligned phases.
      if (state_q == ST_COMMIT || tick) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            if (gap_q == GAP_MAX) begin
              // Gap elapsed: start a frame, or park here until enabled.
              if (enable) begin
                gap_q      <= '0;
                load_cnt_q <= 1'b0;
                shreg_q    <= '1;
                joy_load_n <= 1'b0;
                state_q    <= ST_LOAD;
              end
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
        end

        ST_LOAD: begin
          if (tick) begin
            if (load_cnt_q) begin
              joy_load_n <= 1'b1;
              bit_q      <= '0;
              phase_q    <= 1'b0;
              state_q    <= ST_SHIFT;
            end else begin
              load_cnt_q <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            if (!phase_q) begin
              // Sample before raising joy_clk; the chain advances on the rise.
              shreg_q <= shreg_d;
              joy_clk <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              joy_clk <= 1'b0;
              phase_q <= 1'b0;
              bit_q   <= bit_q + BIT_W'(1);
              if (bit_q == LAST_BIT) begin
                state_q <= ST_COMMIT;
              end
            end
          end
        end

        ST_COMMIT: begin
          joy_state   <= commit_d;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 8'd1;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Testbench for joy_serial_scanner: two instances (2x8 and 1x12 chains) fed
// by 74HC165 chain models carrying random words, checked per frame against
// expected vector, edge count, frame count and frame period.
module tb_joy_serial_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: CLKDIV=2, NUM_JOY=2, BITS_PER_JOY=8, SCAN_GAP=4
  logic        rst_n_a = 1'b1;
  logic        en_a    = 1'b1;
  logic        swap_a  = 1'b0;
  logic        data_a;
  logic        jclk_a, load_a, done_a;
  logic [15:0] state_a;
  logic [7:0]  cnt_a;

  // Instance B: CLKDIV=2, NUM_JOY=1, BITS_PER_JOY=12, SCAN_GAP=4
  logic        rst_n_b = 1'b1;
  logic        en_b    = 1'b1;
  logic        data_b;
  logic        jclk_b, load_b, done_b;
  logic [11:0] state_b;
  logic [7:0]  cnt_b;

  joy_serial_scanner #(.CLKDIV(2), .NUM_JOY(2), .BITS_PER_JOY(8), .SCAN_GAP(4)) u_dut_a (
    .clk(clk), .reset_n(rst_n_a), .enable(en_a), .swap(swap_a), .joy_data(data_a),
    .joy_clk(jclk_a), .joy_load_n(load_a), .joy_state(state_a),
    .frame_done(done_a), .frame_count(cnt_a)
  );

  joy_serial_scanner #(.CLKDIV(2), .NUM_JOY(1), .BITS_PER_JOY(12), .SCAN_GAP(4)) u_dut_b (
    .clk(clk), .reset_n(rst_n_b), .enable(en_b), .swap(swap_a), .joy_data(data_b),
    .joy_clk(jclk_b), .joy_load_n(load_b), .joy_state(state_b),
    .frame_done(done_b), .frame_count(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Chain models: parallel load while load_n low, shift MSB-first on each joy_clk rise.
  logic [15:0] word_a, chain_a;
  logic [11:0] word_b, chain_b;
  logic        fixed_a   = 1'b1;
  logic        swap_rand = 1'b0;
  int          loads_a   = 0;
  int          frames_b_total = 0;

  assign data_a = chain_a[15];
  assign data_b = chain_b[11];

  always @(negedge load_a or posedge jclk_a)
    if (!load_a) chain_a <= word_a;
    else         chain_a <= {chain_a[14:0], 1'b1};

  always @(negedge load_b or posedge jclk_b)
    if (!load_b) chain_b <= word_b;
    else         chain_b <= {chain_b[10:0], 1'b1};

  // Frame-level reference for A: expected vector is the word the chain
  // loaded, halves exchanged if swap is high at commit.
  initial begin : mon_a
    logic [15:0] pend, exp_v, prev_state;
    logic [7:0]  frames;
    logic        prev_load, prev_jclk, prev_done, per_ok, have_pend;
    int          edges, cyc;
    forever begin
      @(negedge clk);
      if (!rst_n_a) begin
        prev_load = 1'b1; prev_jclk = 1'b0; prev_done = 1'b0; prev_state = 16'hFFFF;
        frames = 8'd0; per_ok = 1'b0; have_pend = 1'b0; edges = 0; cyc = 0;
        word_a = fixed_a ? 16'hA55A : 16'($urandom);
      end else begin
        cyc++;
        if (!en_a) per_ok = 1'b0;
        if (prev_load && !load_a) begin
          pend = word_a; have_pend = 1'b1; edges = 0; loads_a++;
          word_a = fixed_a ? 16'hA55A : 16'($urandom);
        end
        if (!prev_jclk && jclk_a) edges++;
        if (done_a) begin
          exp_v = swap_a ? {pend[7:0], pend[15:8]} : pend;
          check_eq("a_state", 32'(state_a), 32'(exp_v));
          check_eq("a_edges", 32'(edges), 32'd16);
          check_eq("a_loaded", 32'(have_pend), 32'd1);
          check_eq("a_pulse_width", 32'(prev_done), 32'd0);
          frames = frames + 8'd1;
          check_eq("a_count", 32'(cnt_a), 32'(frames));
          if (per_ok) check_eq("a_period", 32'(cyc), 32'd77);
          cyc = 0; per_ok = 1'b1; have_pend = 1'b0;
        end else begin
          check_eq("a_hold", 32'(state_a), 32'(prev_state));
        end
        prev_load = load_a; prev_jclk = jclk_a; prev_done = done_a; prev_state = state_a;
      end
    end
  end

  // Frame-level reference for B: single port, swap must be ignored.
  initial begin : mon_b
    logic [11:0] pend, prev_state;
    logic [7:0]  frames;
    logic        prev_load, prev_jclk, per_ok;
    int          edges, cyc;
    forever begin
      @(negedge clk);
      if (!rst_n_b) begin
        prev_load = 1'b1; prev_jclk = 1'b0; prev_state = 12'hFFF;
        frames = 8'd0; per_ok = 1'b0; edges = 0; cyc = 0;
        word_b = 12'($urandom);
      end else begin
        cyc++;
        if (prev_load && !load_b) begin
          pend = word_b; edges = 0; word_b = 12'($urandom);
        end
        if (!prev_jclk && jclk_b) edges++;
        if (done_b) begin
          check_eq("b_state", 32'(state_b), 32'(pend));
          check_eq("b_edges", 32'(edges), 32'd12);
          frames = frames + 8'd1;
          frames_b_total++;
          check_eq("b_count", 32'(cnt_b), 32'(frames));
          if (per_ok) check_eq("b_period", 32'(cyc), 32'd61);
          cyc = 0; per_ok = 1'b1;
        end else begin
          check_eq("b_hold", 32'(state_b), 32'(prev_state));
        end
        prev_load = load_b; prev_jclk = jclk_b; prev_state = state_b;
      end
    end
  end

  // One clk of stimulus; swap only ever moves while joy_clk is high (mid-SHIFT).
  task automatic step();
    @(negedge clk);
    if (swap_rand && jclk_a && ($urandom_range(0, 7) == 0)) swap_a = ~swap_a;
  endtask

  task automatic wait_done_a(input int n);
    int seen   = 0;
    int budget = n * 100 + 200;
    while (seen < n && budget > 0) begin
      step();
      budget--;
      if (done_a) seen++;
    end
    check_eq("a_wait_done", 32'(seen), 32'(n));
  endtask

  task automatic wait_jclk_a(input int n);
    int   seen   = 0;
    int   budget = 600;
    logic prev   = jclk_a;
    while (seen < n && budget > 0) begin
      step();
      budget--;
      if (!prev && jclk_a) seen++;
      prev = jclk_a;
    end
    check_eq("a_wait_jclk", 32'(seen), 32'(n));
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_state"}, 32'(state_a), 32'hFFFF);
    check_eq({tag, "_jclk"},  32'(jclk_a),  32'd0);
    check_eq({tag, "_load"},  32'(load_a),  32'd1);
    check_eq({tag, "_done"},  32'(done_a),  32'd0);
    check_eq({tag, "_count"}, 32'(cnt_a),   32'd0);
  endtask

  // Release reset and confirm the first load strobe lands exactly 8 clks later.
  task automatic release_a();
    @(negedge clk);
    rst_n_a = 1'b1;
    repeat (7) @(posedge clk);
    #1 check_eq("a_first_load_early", 32'(load_a), 32'd1);
    @(posedge clk);
    #1 check_eq("a_first_load", 32'(load_a), 32'd0);
  endtask

  initial begin : main
    int l0;
    #2;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #1;
    check_reset_a("a_rst");
    check_eq("b_rst_state", 32'(state_b), 32'hFFF);
    check_eq("b_rst_count", 32'(cnt_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    release_a();

    // Fixed A55A frames, then swap set mid-SHIFT, then cleared mid-SHIFT.
    wait_done_a(2);
    wait_jclk_a(1);
    swap_a = 1'b1;
    wait_done_a(1);
    wait_jclk_a(5);
    swap_a = 1'b0;
    wait_done_a(1);

    // Random words and random mid-SHIFT swap toggles.
    fixed_a   = 1'b0;
    swap_rand = 1'b1;
    wait_done_a(6);

    // Enable dropped mid-SHIFT: frame still commits, then scanning parks.
    wait_jclk_a(3);
    en_a = 1'b0;
    wait_done_a(1);
    l0 = loads_a;
    repeat (300) step();
    check_eq("a_gated_loads", 32'(loads_a - l0), 32'd0);
    check_eq("a_gated_load_n", 32'(load_a), 32'd1);
    en_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check_eq("a_reenable_load", 32'(load_a), 32'd0);

    // Reset while bit 7 is being shifted.
    wait_jclk_a(8);
    rst_n_a = 1'b0;
    #1;
    check_reset_a("a_midrst");
    repeat (2) @(negedge clk);
    release_a();

    // 256 frames from reset brings frame_count back to 0.
    wait_done_a(256);
    check_eq("a_wrap", 32'(cnt_a), 32'd0);
    wait_done_a(3);
    check_eq("b_frames_seen", 32'(frames_b_total > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
